// File: rtl/vc_queue_bank_if.sv
// Ingress, grant and egress bundle for the per-VC queue bank.
// Carries almost_full only when QOS_ALMOST_FULL_EN is defined.
interface vc_queue_bank_if #(
    parameter int DATA_WIDTH = 10
);
    logic                  push;
    logic [1:0]            push_class;
    logic [DATA_WIDTH-1:0] push_data;
    logic [3:0]            grant;
    logic [3:0]            req;
    logic [3:0]            full;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  err_ovf;
    logic                  err_grant;
`ifdef QOS_ALMOST_FULL_EN
    logic [3:0]            almost_full;

    modport master (
        output push, push_class, push_data, grant,
        input  req, full, data_out, valid_out,
        input  err_ovf, err_grant, almost_full
    );
    modport slave (
        input  push, push_class, push_data, grant,
        output req, full, data_out, valid_out,
        output err_ovf, err_grant, almost_full
    );
`else
    modport master (
        output push, push_class, push_data, grant,
        input  req, full, data_out, valid_out,
        input  err_ovf, err_grant
    );
    modport slave (
        input  push, push_class, push_data, grant,
        output req, full, data_out, valid_out,
        output err_ovf, err_grant
    );
`endif
endinterface

// File: rtl/vc_queue_bank.sv
// Four per-VC FIFOs feeding a one-hot-grant arbiter, registered egress.
// Optional almost_full flags under QOS_ALMOST_FULL_EN.
module vc_queue_bank #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
`ifdef QOS_ALMOST_FULL_EN
    ,
    parameter int AF_LEVEL   = DEPTH - 2
`endif
) (
    input logic            clk,
    input logic            reset,
    vc_queue_bank_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT =
        (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
        ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [4][DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr [4];
    logic [ADDR_WIDTH-1:0] rd_ptr [4];
    logic [ADDR_WIDTH:0]   count  [4];

    logic       one_hot;
    logic [1:0] pop_idx;
    logic       pop_ok;
    logic       bad_grant;
    logic       ovf;
    logic [3:0] push_vc;
    logic [3:0] pop_vc;
    logic [3:0] wr_en;
    logic [3:0] req_q;
    logic [3:0] full_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_q[i]  = (count[i] != '0);
            full_q[i] = (count[i] == FULL_CNT);
        end
    end

    assign bus.req  = req_q;
    assign bus.full = full_q;

    always_comb begin
        one_hot = (bus.grant != 4'b0000) &&
                  ((bus.grant & (bus.grant - 4'd1)) == 4'b0000);
        pop_idx = 2'd0;
        unique case (1'b1)
            bus.grant[1]: pop_idx = 2'd1;
            bus.grant[2]: pop_idx = 2'd2;
            bus.grant[3]: pop_idx = 2'd3;
            default:      pop_idx = 2'd0;
        endcase
        pop_ok    = one_hot && req_q[pop_idx];
        bad_grant = (bus.grant != 4'b0000) && !pop_ok;
    end

    // A full queue still accepts a push when the same edge pops it.
    always_comb begin
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_vc[i] = bus.push && (bus.push_class == 2'(i));
            pop_vc[i]  = pop_ok && bus.grant[i];
            wr_en[i]   = push_vc[i] && (!full_q[i] || pop_vc[i]);
            if (push_vc[i] && full_q[i] && !pop_vc[i])
                ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i])
                mem[i][wr_ptr[i]] <= bus.push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en[i])
                    wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop_vc[i])
                    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                if (wr_en[i] && !pop_vc[i])
                    count[i] <= count[i] + 1'b1;
                else if (!wr_en[i] && pop_vc[i])
                    count[i] <= count[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.err_ovf   <= 1'b0;
            bus.err_grant <= 1'b0;
        end else begin
            bus.valid_out <= pop_ok;
            if (pop_ok)
                bus.data_out <= mem[pop_idx][rd_ptr[pop_idx]];
            if (ovf)
                bus.err_ovf <= 1'b1;
            if (bad_grant)
                bus.err_grant <= 1'b1;
        end
    end

`ifdef QOS_ALMOST_FULL_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT =
        (ADDR_WIDTH + 1)'(AF_LEVEL);

    always_comb begin
        for (int i = 0; i < 4; i++)
            bus.almost_full[i] = (count[i] >= AF_CNT);
    end
`endif
endmodule

// File: tb/tb_vc_queue_bank.sv
// Directed self-checking bench for vc_queue_bank.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_vc_queue_bank;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vc_queue_bank_if #(.DATA_WIDTH(10)) bus ();

    vc_queue_bank #(
        .DATA_WIDTH(10),
        .DEPTH(8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic       p,
                         input logic [1:0] c,
                         input logic [9:0] d,
                         input logic [3:0] g);
        bus.push       = p;
        bus.push_class = c;
        bus.push_data  = d;
        bus.grant      = g;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 2'd0, 10'h0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // reset state
        chk("rst_req", bus.req, 4'b0000);
        chk("rst_full", bus.full, 4'b0000);
        chk("rst_valid", bus.valid_out, 1'b0);
        chk("rst_data", bus.data_out, 10'h000);
        chk("rst_ovf", bus.err_ovf, 1'b0);
        chk("rst_gerr", bus.err_grant, 1'b0);

        // basic push / pop on VC0 and VC2
        drive(1'b1, 2'd0, 10'h001, 4'b0000); step();
        drive(1'b1, 2'd0, 10'h002, 4'b0000); step();
        drive(1'b1, 2'd2, 10'h155, 4'b0000); step();
        drive(1'b0, 2'd0, 10'h000, 4'b0000);
        chk("basic_req", bus.req, 4'b0101);
        chk("basic_v0", bus.valid_out, 1'b0);
        drive(1'b0, 2'd0, 10'h000, 4'b0001); step();
        chk("pop1_v", bus.valid_out, 1'b1);
        chk("pop1_d", bus.data_out, 10'h001);
        drive(1'b0, 2'd0, 10'h000, 4'b0001); step();
        chk("pop2_v", bus.valid_out, 1'b1);
        chk("pop2_d", bus.data_out, 10'h002);
        drive(1'b0, 2'd0, 10'h000, 4'b0100); step();
        chk("pop3_v", bus.valid_out, 1'b1);
        chk("pop3_d", bus.data_out, 10'h155);
        drive(1'b0, 2'd0, 10'h000, 4'b0000); step();
        chk("idle_v", bus.valid_out, 1'b0);
        chk("idle_hold", bus.data_out, 10'h155);
        chk("basic_req0", bus.req, 4'b0000);

        // fill VC3, overflow, then push+pop on full
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'd3, 10'(10'h300 + k), 4'b0000);
            step();
        end
        chk("fill_full", bus.full, 4'b1000);
        chk("fill_req", bus.req, 4'b1000);
        chk("fill_ovf0", bus.err_ovf, 1'b0);
`ifdef QOS_ALMOST_FULL_EN
        chk("fill_af", bus.almost_full, 4'b1000);
`endif
        drive(1'b1, 2'd3, 10'h3FF, 4'b0000); step();
        chk("ovf_set", bus.err_ovf, 1'b1);
        chk("ovf_full", bus.full, 4'b1000);
        drive(1'b1, 2'd3, 10'h3AA, 4'b1000); step();
        chk("pp_v", bus.valid_out, 1'b1);
        chk("pp_d", bus.data_out, 10'h300);
        chk("pp_full", bus.full, 4'b1000);
        for (int k = 1; k < 9; k++) begin
            drive(1'b0, 2'd0, 10'h000, 4'b1000);
            step();
            chk("drain3_v", bus.valid_out, 1'b1);
            chk("drain3_d", bus.data_out,
                (k == 8) ? 32'h3AA : 32'(10'h300 + k));
        end
        drive(1'b0, 2'd0, 10'h000, 4'b0000); step();
        chk("drain3_req", bus.req, 4'b0000);
        chk("drain3_full", bus.full, 4'b0000);
        chk("drain3_gerr", bus.err_grant, 1'b0);

        // VC1 pointer wrap with interleaved grants
        drive(1'b1, 2'd1, 10'h100, 4'b0000); step();
        for (int k = 1; k < 10; k++) begin
            drive(1'b1, 2'd1, 10'(10'h100 + k), 4'b0010);
            step();
            chk("wrap_v", bus.valid_out, 1'b1);
            chk("wrap_d", bus.data_out, 32'(10'h100 + k - 1));
        end
        drive(1'b0, 2'd0, 10'h000, 4'b0010); step();
        chk("wrap_last", bus.data_out, 10'h109);
        chk("wrap_req", bus.req, 4'b0000);
        chk("wrap_gerr", bus.err_grant, 1'b0);

        // illegal grants
        drive(1'b1, 2'd0, 10'h011, 4'b0000); step();
        drive(1'b1, 2'd1, 10'h022, 4'b0000); step();
        drive(1'b0, 2'd0, 10'h000, 4'b0011); step();
        chk("ill2_v", bus.valid_out, 1'b0);
        chk("ill2_gerr", bus.err_grant, 1'b1);
        chk("ill2_req", bus.req, 4'b0011);
        drive(1'b0, 2'd0, 10'h000, 4'b0100); step();
        chk("illE_v", bus.valid_out, 1'b0);
        chk("illE_req", bus.req, 4'b0011);
        drive(1'b0, 2'd0, 10'h000, 4'b0001); step();
        chk("ill_pop0", bus.data_out, 10'h011);
        drive(1'b0, 2'd0, 10'h000, 4'b0010); step();
        chk("ill_pop1", bus.data_out, 10'h022);
        // push into empty VC2 with grant: no bypass
        drive(1'b1, 2'd2, 10'h0AB, 4'b0100); step();
        chk("nobyp_v", bus.valid_out, 1'b0);
        chk("nobyp_req", bus.req, 4'b0100);
        drive(1'b0, 2'd0, 10'h000, 4'b0100); step();
        chk("nobyp_d", bus.data_out, 10'h0AB);
        chk("nobyp_vv", bus.valid_out, 1'b1);

        // reset mid-operation
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'd0, 10'(10'h040 + k), 4'b0000);
            step();
        end
        drive(1'b0, 2'd0, 10'h000, 4'b0001); step();
        chk("mid_v", bus.valid_out, 1'b1);
        chk("mid_d", bus.data_out, 10'h040);
        drive(1'b0, 2'd0, 10'h000, 4'b0000);
        reset = 1'b1;
        #1;
        chk("arst_req", bus.req, 4'b0000);
        chk("arst_v", bus.valid_out, 1'b0);
        chk("arst_d", bus.data_out, 10'h000);
        chk("arst_gerr", bus.err_grant, 1'b0);
        chk("arst_ovf", bus.err_ovf, 1'b0);
        step();
        reset = 1'b0;
        step();
        drive(1'b0, 2'd0, 10'h000, 4'b0001); step();
        chk("post_v", bus.valid_out, 1'b0);
        chk("post_gerr", bus.err_grant, 1'b1);
        drive(1'b0, 2'd0, 10'h000, 4'b0000); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vc_queue_bank.md
Name: vc_queue_bank

Overview:
- Four per-virtual-channel FIFOs sit directly upstream of the QoS round-robin/table/weighted arbiter.
- Ingress packet words are pushed by traffic class (VC0..VC3). The bank presents a non-empty request vector to the arbiter.
- The bank consumes the arbiter's 4-bit one-hot grant (`out`) and pops the granted queue onto a single registered egress port.

Parameters:
- DATA_WIDTH, 10, width of each queued word.
- DEPTH, 8, entries per VC FIFO; must be a power of two, minimum 2.
- ADDR_WIDTH, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write request for this cycle.
- push_class  input  2  target VC (0..3) for the push.
- push_data  input  DATA_WIDTH  word to enqueue.
- grant  input  4  one-hot grant from arbiter output `out`; 4'b0000 = no grant.
- req  output  4  bit i = VC i FIFO non-empty; feeds the arbiter.
- full  output  4  bit i = VC i FIFO holds DEPTH words.
- data_out  output  DATA_WIDTH  popped word, registered.
- valid_out  output  1  data_out valid this cycle.
- err_ovf  output  1  sticky: push dropped on full queue.
- err_grant  output  1  sticky: illegal grant (not one-hot and not zero, or granted queue empty).

Behaviour:
- Reset (async assert, sync-released by clk):
  - All read/write pointers and counts = 0.
  - req = 4'b0000, full = 4'b0000.
  - data_out = 0, valid_out = 0, err_ovf = 0, err_grant = 0.
- Storage and counts:
  - Each FIFO is a circular buffer with ADDR_WIDTH pointers that wrap DEPTH-1 -> 0.
  - Count is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Flags:
  - req[i] = (count_i != 0) and full[i] = (count_i == DEPTH).
  - Both are derived from registered counts, so they reflect state after the last edge.
- Push:
  - When push=1 and the target queue is not full, push_data is written at the write pointer, the pointer increments, and the count increments.
  - When push=1 and the target is full with no same-VC pop this cycle, the word is dropped, state is unchanged, and err_ovf is set.
- Pop:
  - When grant is one-hot with bit i, and req[i]=1, the word at rd_ptr_i is registered into data_out, valid_out=1 on the next edge, rd_ptr_i increments, and count_i decrements.
  - Latency: grant in cycle N gives data_out/valid_out in cycle N+1.
- No grant:
  - grant = 0 gives valid_out = 0 next cycle.
  - data_out holds its last value.
- Illegal grant:
  - Applies when grant has more than one bit set, or the granted queue is empty.
  - No pop occurs, valid_out = 0 next cycle, and err_grant is set.
- Simultaneous push and pop, same VC:
  - Both operations occur and the count is unchanged.
  - This is allowed even when the queue is full, since the pop frees the slot in the same edge.
- Simultaneous push into an empty queue plus grant to that queue:
  - Treated as an illegal grant, because req was 0. There is no bypass.
  - The push is still accepted.
- Different-VC push and pop: fully independent.
- Sticky errors clear only on reset.
- Reset mid-operation: all queued words are discarded and outputs return to reset values immediately.

Optional Feature:
- QOS_ALMOST_FULL_EN defined:
  - Adds parameter AF_LEVEL (default DEPTH-2) and output almost_full (4 bits).
  - almost_full[i] = (count_i >= AF_LEVEL), registered-count based, reset 0.
  - Upstream uses it for credit throttling.
- Not defined: neither the port nor the parameter exists. All other behaviour is identical.

Test Plan:
- Reset then idle -> req=0000, full=0000, valid_out=0, data_out=0, both error flags 0.
- Push VC0 words 0x001, 0x002, then VC2 word 0x155 -> req=0101. Grants 0001, 0001, 0100 on consecutive cycles give data_out 0x001, 0x002, 0x155 each one cycle later with valid_out=1. Final req=0000.
- Fill VC3 with 8 words (full[3]=1), push a 9th -> dropped, err_ovf=1. Same cycle push+grant 1000 on a full VC3 -> pop first word, push accepted, full[3] stays 1.
- Push 10 words through VC1 with interleaved grants 0010 -> pointers wrap, output order equals input order.
- Grant 0011 with VC0 and VC1 non-empty -> no pop, valid_out=0, err_grant=1, counts unchanged. Grant 0100 with VC2 empty -> same result.
- Reset asserted with 3 words queued in VC0 -> req=0000 and valid_out=0 immediately. After release, a grant of 0001 sets err_grant.
